// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types, default sizes and helpers for the BCD-to-binary unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int c_DIGITS = 4;
    localparam int c_BIN_W  = 14;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    function automatic logic nibble_valid(input logic [3:0] nib);
        return (nib <= 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module   : bcd_digit_adjust
// Brief    : Single-digit reverse double-dabble correction (d >= 8 ? d-3 : d).
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adjust (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    // Bit 3 set is exactly the d >= 8 condition.
    assign d_out = d_in[3] ? (d_in - 4'd3) : d_in;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// Module   : bcd_to_bin_seq
// Brief    : Multi-cycle packed-BCD to binary converter, start/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = c_DIGITS,
    parameter int BIN_W  = c_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int                 c_BCD_W = 4 * DIGITS;
    localparam int                 c_SR_W  = c_BCD_W + BIN_W;
    localparam int                 c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIN_W - 1);

    state_t               state_q, state_d;
    logic [c_BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]     acc_q, acc_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [BIN_W-1:0]     bin_out_q, bin_out_d;

    logic [c_SR_W-1:0]    w_sr_shift;
    logic [c_BCD_W-1:0]   w_bcd_shift;
    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [BIN_W-1:0]     w_acc_shift;
    logic                 w_in_valid;

    // The LSB of the digit field falls into the MSB of the binary accumulator.
    assign w_sr_shift  = {bcd_q, acc_q} >> 1;
    assign w_bcd_shift = w_sr_shift[c_SR_W-1:BIN_W];
    assign w_acc_shift = w_sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adj (
            .d_in  (w_bcd_shift[4*g +: 4]),
            .d_out (w_bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        w_in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!nibble_valid(bcd_in[4*i +: 4])) begin
                w_in_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bin_out_d = bin_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (w_in_valid) begin
                        bcd_d   = bcd_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CONV;
                    end else begin
                        // Malformed operand: report immediately, no conversion.
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        bin_out_d = '0;
                    end
                end
            end
            CONV: begin
                bcd_d = w_bcd_adj;
                acc_d = w_acc_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    bin_out_d = w_acc_shift;
                    err_d     = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bin_out_q <= bin_out_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = bin_out_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
// Module   : tb_bcd_to_bin_seq
// Brief    : Scoreboard bench for bcd_to_bin_seq with a decimal reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

    localparam int c_BIN_W = 14;

    typedef struct {
        logic [c_BIN_W-1:0] bin;
        logic               err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [15:0]         bcd_in = '0;
    logic                busy;
    logic                done;
    logic [c_BIN_W-1:0]  bin_out;
    logic                err;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sbq[$];

    logic                m_busy = 1'b0;
    logic                m_done = 1'b0;
    int                  m_rem  = 0;
    logic [c_BIN_W-1:0]  held_bin = '0;
    logic                held_err = 1'b0;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(c_BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit all_valid(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_value(input logic [15:0] v);
        int s = 0;
        for (int i = 3; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
        return s;
    endfunction

    // Transaction-level model: acceptance, latency and expected result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rem  <= 0;
            sbq.delete();
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (all_valid(bcd_in)) begin
                    m_busy <= 1'b1;
                    m_rem  <= c_BIN_W;
                    sbq.push_back('{bin: c_BIN_W'(bcd_value(bcd_in)), err: 1'b0});
                end else begin
                    m_done <= 1'b1;
                    sbq.push_back('{bin: '0, err: 1'b1});
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_bin <= '0;
            held_err <= 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("bin_out", 32'(bin_out), 32'(e.bin));
                    chk("err", 32'(err), 32'(e.err));
                    if (!e.err) chk("residual_digits", 32'(dut.bcd_q), 32'd0);
                    held_bin <= e.bin;
                    held_err <= e.err;
                end
            end else begin
                chk("hold_bin", 32'(bin_out), 32'(held_bin));
                chk("hold_err", 32'(err), 32'(held_err));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((m_busy || start) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [15:0] v);
        wait_idle();
        @(negedge clk);
        start  = 1'b1;
        bcd_in = v;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        issue(16'h0000);
        issue(16'h9999);

        // Second operand waits with start held and is taken right after done.
        wait_idle();
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0042;
        @(negedge clk);
        bcd_in = 16'h1234;
        repeat (15) @(negedge clk);
        start  = 1'b0;

        issue(16'h12A4);

        issue(16'h3141);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h2718;
        @(negedge clk);
        start  = 1'b0;

        issue(16'h5678);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bin", 32'(bin_out), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        issue(16'h0100);

        for (int k = 0; k < 40; k++) begin
            for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(v);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
                start  = 1'b1;
                bcd_in = 16'($urandom);
                @(negedge clk);
                start  = 1'b0;
            end
        end

        wait_idle();
        repeat (20) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
